// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the i2c_master transaction sequencer.
package i2c_seq_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_TO_WIDTH   = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RISE,
        S_FALL,
        S_FIN,
        S_ABORT
    } state_t;

    // Length fields carry one extra bit so a full buffer (DEPTH bytes) is representable.
    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/i2c_seq_buf.sv
// DEPTH x 8 byte buffer: registered host port, combinational sequencer port.
module i2c_seq_buf
    import i2c_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    output logic [7:0]            host_rdata,
    input  logic [ADDR_WIDTH-1:0] seq_addr,
    input  logic                  seq_we,
    input  logic [7:0]            seq_wdata,
    output logic [7:0]            seq_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [7:0] mem [DEPTH];

    // Byte storage; the sequencer write is last so it wins a same-index collision.
    // NOTE: the array has no reset so it maps onto RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (host_we) mem[host_addr] <= host_wdata;
        if (seq_we)  mem[seq_addr]  <= seq_wdata;
    end

    // Host read port with one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) host_rdata <= 8'h00;
        else     host_rdata <= mem[host_addr];
    end

    assign seq_rdata = mem[seq_addr];

endmodule

// File: rtl/i2c_seq.sv
// Runs a full I2C transfer (write phase, optional repeated-start read phase, stop)
// by driving i2c_master's ena/rw/data_wr handshake from an internal byte buffer.
module i2c_seq
    import i2c_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int TO_WIDTH   = DEFAULT_TO_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [6:0]            dev_addr,
    input  logic [ADDR_WIDTH:0]   wr_len,
    input  logic [ADDR_WIDTH:0]   rd_len,
    input  logic                  buf_we,
    input  logic [ADDR_WIDTH-1:0] buf_addr,
    input  logic [7:0]            buf_wdata,
    output logic [7:0]            buf_rdata,
    output logic                  active,
    output logic                  done,
    output logic                  err_nack,
    output logic                  err_timeout,
    output logic                  err_len,
    output logic                  i2c_ena,
    output logic [6:0]            i2c_addr,
    output logic                  i2c_rw,
    output logic [7:0]            i2c_data_wr,
    input  logic                  i2c_busy,
    input  logic                  i2c_ack_error,
    input  logic [7:0]            i2c_data_rd
);

    localparam int LEN_W = len_width(ADDR_WIDTH);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [LEN_W:0] DEPTH_N = (LEN_W + 1)'(DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] k;
    logic [ADDR_WIDTH-1:0] k_next;
    logic [ADDR_WIDTH-1:0] n_last;
    logic [LEN_W-1:0]      wr_len_q;
    logic [TO_WIDTH-1:0]   wd;
    logic [TO_WIDTH-1:0]   wd_inc;
    logic                  wd_expired;
    logic                  busy_q;
    logic                  rise;
    logic                  fall;
    logic [LEN_W:0]        total;
    logic                  len_ok;
    logic                  is_read_k;
    logic                  is_read_next;
    logic [ADDR_WIDTH-1:0] seq_addr;
    logic                  seq_we;
    logic [7:0]            seq_rdata;

    assign rise         = i2c_busy & ~busy_q;
    assign fall         = ~i2c_busy & busy_q;
    assign k_next       = k + 1'b1;
    assign wd_inc       = wd + 1'b1;
    assign wd_expired   = &wd_inc;
    assign total        = {1'b0, wr_len} + {1'b0, rd_len};
    assign len_ok       = (total != '0) && (total <= DEPTH_N);
    assign is_read_k    = ({1'b0, k} >= wr_len_q);
    assign is_read_next = ({1'b0, k_next} >= wr_len_q);
    assign seq_we       = (state == S_FALL) && fall && is_read_k;

    // Sequencer buffer index: byte 0 when idle, the upcoming byte while waiting for rise, else k.
    always_comb begin
        // NOTE: default assignment first so no path leaves seq_addr unassigned (no latch).
        seq_addr = k;
        if (state == S_IDLE)      seq_addr = '0;
        else if (state == S_RISE) seq_addr = k_next;
    end

    i2c_seq_buf #(.ADDR_WIDTH(ADDR_WIDTH)) u_buf (
        .clk        (clk),
        .rst        (rst),
        .host_we    (buf_we & ~active),
        .host_addr  (buf_addr),
        .host_wdata (buf_wdata),
        .host_rdata (buf_rdata),
        .seq_addr   (seq_addr),
        .seq_we     (seq_we),
        .seq_wdata  (i2c_data_rd),
        .seq_rdata  (seq_rdata)
    );

    // Transfer FSM with registered master-facing outputs, status flags and watchdog.
    // NOTE: non-blocking assignments throughout so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            k           <= '0;
            n_last      <= '0;
            wr_len_q    <= '0;
            wd          <= '0;
            busy_q      <= 1'b0;
            active      <= 1'b0;
            done        <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
            err_len     <= 1'b0;
            i2c_ena     <= 1'b0;
            i2c_addr    <= '0;
            i2c_rw      <= 1'b0;
            i2c_data_wr <= '0;
        end else begin
            busy_q <= i2c_busy;
            done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!len_ok) begin
                            err_len <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            err_nack    <= 1'b0;
                            err_timeout <= 1'b0;
                            err_len     <= 1'b0;
                            i2c_addr    <= dev_addr;
                            wr_len_q    <= wr_len;
                            n_last      <= total[ADDR_WIDTH-1:0] - 1'b1;
                            k           <= '0;
                            i2c_rw      <= (wr_len == '0);
                            i2c_data_wr <= seq_rdata;
                            i2c_ena     <= 1'b1;
                            active      <= 1'b1;
                            wd          <= '0;
                            state       <= S_RISE;
                        end
                    end
                end
                S_RISE: begin
                    if (rise) begin
                        if (k == n_last) begin
                            i2c_ena <= 1'b0;
                        end else begin
                            i2c_rw      <= is_read_next;
                            i2c_data_wr <= seq_rdata;
                        end
                        wd    <= '0;
                        state <= S_FALL;
                    end else if (wd_expired) begin
                        err_timeout <= 1'b1;
                        i2c_ena     <= 1'b0;
                        state       <= S_ABORT;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_FALL: begin
                    if (fall) begin
                        if (i2c_ack_error) begin
                            err_nack <= 1'b1;
                            i2c_ena  <= 1'b0;
                            state    <= S_ABORT;
                        end else if (k == n_last) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            k     <= k_next;
                            wd    <= '0;
                            state <= S_RISE;
                        end
                    end else if (wd_expired) begin
                        err_timeout <= 1'b1;
                        i2c_ena     <= 1'b0;
                        state       <= S_ABORT;
                    end else begin
                        wd <= wd_inc;
                    end
                end
                S_FIN: begin
                    active <= 1'b0;
                    state  <= S_IDLE;
                end
                S_ABORT: begin
                    i2c_ena <= 1'b0;
                    if (!i2c_busy) begin
                        done   <= 1'b1;
                        active <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_seq.sv
// Directed bench for i2c_seq; the bench plays the i2c_master's busy/ack/data_rd side.
module tb_i2c_seq;

    localparam int AW = 4;
    localparam int TW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [6:0]    dev_addr;
    logic [AW:0]   wr_len;
    logic [AW:0]   rd_len;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_wdata;
    logic [7:0]    buf_rdata;
    logic          active;
    logic          done;
    logic          err_nack;
    logic          err_timeout;
    logic          err_len;
    logic          i2c_ena;
    logic [6:0]    i2c_addr;
    logic          i2c_rw;
    logic [7:0]    i2c_data_wr;
    logic          i2c_busy;
    logic          i2c_ack_error;
    logic [7:0]    i2c_data_rd;

    int checks = 0;
    int passed = 0;
    int done_cnt = 0;

    i2c_seq #(.ADDR_WIDTH(AW), .TO_WIDTH(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dev_addr      (dev_addr),
        .wr_len        (wr_len),
        .rd_len        (rd_len),
        .buf_we        (buf_we),
        .buf_addr      (buf_addr),
        .buf_wdata     (buf_wdata),
        .buf_rdata     (buf_rdata),
        .active        (active),
        .done          (done),
        .err_nack      (err_nack),
        .err_timeout   (err_timeout),
        .err_len       (err_len),
        .i2c_ena       (i2c_ena),
        .i2c_addr      (i2c_addr),
        .i2c_rw        (i2c_rw),
        .i2c_data_wr   (i2c_data_wr),
        .i2c_busy      (i2c_busy),
        .i2c_ack_error (i2c_ack_error),
        .i2c_data_rd   (i2c_data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses away from the active edge.
    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        buf_we = 1'b1; buf_addr = a; buf_wdata = d;
        tick();
        buf_we = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [7:0] d);
        buf_addr = a;
        tick();
        d = buf_rdata;
    endtask

    task automatic start_xfer(input logic [6:0] da, input logic [AW:0] wl, input logic [AW:0] rl);
        start = 1'b1; dev_addr = da; wr_len = wl; rd_len = rl;
        tick();
        start = 1'b0;
    endtask

    // One byte from the master's side: latch ena/rw/data at busy rise, finish the ACK slot at busy fall.
    task automatic master_byte(input logic nack, input logic [7:0] rd,
                               output logic ena_o, output logic rw_o, output logic [7:0] d_o);
        ena_o = i2c_ena; rw_o = i2c_rw; d_o = i2c_data_wr;
        i2c_busy = 1'b1;
        tick(); tick(); tick();
        i2c_ack_error = nack; i2c_data_rd = rd; i2c_busy = 1'b0;
        tick();
        i2c_ack_error = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (i2c_ena !== 1'b0) $display("FAIL rst_ena: got %b want 0", i2c_ena); else passed++;
        checks++; if (i2c_rw !== 1'b0) $display("FAIL rst_rw: got %b want 0", i2c_rw); else passed++;
        checks++; if (i2c_data_wr !== 8'h00) $display("FAIL rst_data_wr: got %h want 00", i2c_data_wr); else passed++;
        checks++; if (i2c_addr !== 7'h00) $display("FAIL rst_addr: got %h want 00", i2c_addr); else passed++;
        checks++; if (active !== 1'b0) $display("FAIL rst_active: got %b want 0", active); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        checks++; if ({err_nack, err_timeout, err_len} !== 3'b000)
            $display("FAIL rst_errs: got %b want 000", {err_nack, err_timeout, err_len}); else passed++;
        checks++; if (buf_rdata !== 8'h00) $display("FAIL rst_buf_rdata: got %h want 00", buf_rdata); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write2();
        logic e0, r0, e1, r1;
        logic [7:0] d0, d1, rb;
        int dc;
        host_write(4'd0, 8'hA5);
        host_write(4'd1, 8'h3C);
        host_write(4'd5, 8'h77);
        dc = done_cnt;
        start_xfer(7'h50, 5'd2, 5'd0);
        checks++; if (i2c_ena !== 1'b1) $display("FAIL w2_ena_start: got %b want 1", i2c_ena); else passed++;
        checks++; if (active !== 1'b1) $display("FAIL w2_active: got %b want 1", active); else passed++;
        checks++; if (i2c_addr !== 7'h50) $display("FAIL w2_addr: got %h want 50", i2c_addr); else passed++;
        // Host write while active must be dropped.
        buf_we = 1'b1; buf_addr = 4'd5; buf_wdata = 8'hEE;
        master_byte(1'b0, 8'h00, e0, r0, d0);
        buf_we = 1'b0;
        master_byte(1'b0, 8'h00, e1, r1, d1);
        checks++; if (d0 !== 8'hA5 || r0 !== 1'b0 || e0 !== 1'b1)
            $display("FAIL w2_byte0: got ena=%b rw=%b data=%h want ena=1 rw=0 data=a5", e0, r0, d0); else passed++;
        checks++; if (d1 !== 8'h3C || r1 !== 1'b0 || e1 !== 1'b1)
            $display("FAIL w2_byte1: got ena=%b rw=%b data=%h want ena=1 rw=0 data=3c", e1, r1, d1); else passed++;
        checks++; if (i2c_ena !== 1'b0) $display("FAIL w2_ena_drop: got %b want 0", i2c_ena); else passed++;
        checks++; if (done !== 1'b1) $display("FAIL w2_done: got %b want 1", done); else passed++;
        tick();
        checks++; if (done !== 1'b0 || active !== 1'b0)
            $display("FAIL w2_end: got done=%b active=%b want 0 0", done, active); else passed++;
        checks++; if (done_cnt - dc !== 1) $display("FAIL w2_done_count: got %0d want 1", done_cnt - dc); else passed++;
        checks++; if ({err_nack, err_timeout, err_len} !== 3'b000)
            $display("FAIL w2_errs: got %b want 000", {err_nack, err_timeout, err_len}); else passed++;
        host_read(4'd5, rb);
        checks++; if (rb !== 8'h77) $display("FAIL w2_we_dropped: got %h want 77", rb); else passed++;
    endtask

    task automatic test_read();
        logic e0, r0, e1, r1, e2, r2;
        logic [7:0] d0, d1, d2, rb;
        int dc;
        host_write(4'd0, 8'h10);
        host_write(4'd1, 8'hFF);
        host_write(4'd2, 8'hFF);
        dc = done_cnt;
        start_xfer(7'h21, 5'd1, 5'd2);
        master_byte(1'b0, 8'h00, e0, r0, d0);
        master_byte(1'b0, 8'h11, e1, r1, d1);
        master_byte(1'b0, 8'h22, e2, r2, d2);
        checks++; if (r0 !== 1'b0 || d0 !== 8'h10)
            $display("FAIL rd_byte0: got rw=%b data=%h want rw=0 data=10", r0, d0); else passed++;
        checks++; if (r1 !== 1'b1 || r2 !== 1'b1)
            $display("FAIL rd_rw_seq: got %b %b want 1 1", r1, r2); else passed++;
        checks++; if (e2 !== 1'b1 || i2c_ena !== 1'b0)
            $display("FAIL rd_ena: got last=%b after=%b want 1 0", e2, i2c_ena); else passed++;
        tick();
        checks++; if (done_cnt - dc !== 1) $display("FAIL rd_done_count: got %0d want 1", done_cnt - dc); else passed++;
        host_read(4'd1, rb);
        checks++; if (rb !== 8'h11) $display("FAIL rd_buf1: got %h want 11", rb); else passed++;
        host_read(4'd2, rb);
        checks++; if (rb !== 8'h22) $display("FAIL rd_buf2: got %h want 22", rb); else passed++;
        host_read(4'd0, rb);
        checks++; if (rb !== 8'h10) $display("FAIL rd_buf0: got %h want 10", rb); else passed++;
    endtask

    task automatic test_nack();
        logic e0, r0;
        logic [7:0] d0, rb;
        host_write(4'd0, 8'h01);
        host_write(4'd1, 8'h02);
        host_write(4'd2, 8'h03);
        start_xfer(7'h33, 5'd3, 5'd0);
        master_byte(1'b1, 8'h00, e0, r0, d0);
        checks++; if (err_nack !== 1'b1) $display("FAIL nk_flag: got %b want 1", err_nack); else passed++;
        checks++; if (i2c_ena !== 1'b0) $display("FAIL nk_ena: got %b want 0", i2c_ena); else passed++;
        checks++; if (done !== 1'b0) $display("FAIL nk_done_early: got %b want 0", done); else passed++;
        tick();
        checks++; if (done !== 1'b1) $display("FAIL nk_done: got %b want 1", done); else passed++;
        tick();
        checks++; if (active !== 1'b0 || err_nack !== 1'b1)
            $display("FAIL nk_end: got active=%b nack=%b want 0 1", active, err_nack); else passed++;
        host_read(4'd0, rb);
        checks++; if (rb !== 8'h01) $display("FAIL nk_buf0: got %h want 01", rb); else passed++;
        host_read(4'd1, rb);
        checks++; if (rb !== 8'h02) $display("FAIL nk_buf1: got %h want 02", rb); else passed++;
    endtask

    task automatic test_timeout();
        start_xfer(7'h44, 5'd1, 5'd0);
        checks++; if (err_nack !== 1'b0) $display("FAIL to_nack_cleared: got %b want 0", err_nack); else passed++;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (err_timeout !== 1'b0) $display("FAIL to_early: got %b want 0", err_timeout); else passed++;
        tick();
        checks++; if (err_timeout !== 1'b1 || i2c_ena !== 1'b0)
            $display("FAIL to_fire: got to=%b ena=%b want 1 0", err_timeout, i2c_ena); else passed++;
        tick();
        checks++; if (done !== 1'b1 || active !== 1'b0)
            $display("FAIL to_done: got done=%b active=%b want 1 0", done, active); else passed++;
        tick();
    endtask

    task automatic test_err_len();
        start_xfer(7'h10, 5'd0, 5'd0);
        checks++; if (err_len !== 1'b1 || done !== 1'b1)
            $display("FAIL len0: got err_len=%b done=%b want 1 1", err_len, done); else passed++;
        checks++; if (i2c_ena !== 1'b0 || active !== 1'b0)
            $display("FAIL len0_idle: got ena=%b active=%b want 0 0", i2c_ena, active); else passed++;
        tick();
        checks++; if (done !== 1'b0 || i2c_ena !== 1'b0)
            $display("FAIL len0_after: got done=%b ena=%b want 0 0", done, i2c_ena); else passed++;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (err_len !== 1'b0) $display("FAIL len_rst_clear: got %b want 0", err_len); else passed++;
        start_xfer(7'h10, 5'd10, 5'd7);
        checks++; if (err_len !== 1'b1 || done !== 1'b1)
            $display("FAIL len17: got err_len=%b done=%b want 1 1", err_len, done); else passed++;
        tick();
        checks++; if (i2c_ena !== 1'b0 || active !== 1'b0)
            $display("FAIL len17_idle: got ena=%b active=%b want 0 0", i2c_ena, active); else passed++;
    endtask

    task automatic test_reset_mid();
        logic e0, r0;
        logic [7:0] d0;
        int dc;
        host_write(4'd0, 8'hA5);
        host_write(4'd1, 8'h3C);
        start_xfer(7'h55, 5'd2, 5'd0);
        master_byte(1'b0, 8'h00, e0, r0, d0);
        i2c_busy = 1'b1;
        tick();
        dc = done_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0; i2c_busy = 1'b0;
        checks++; if (i2c_ena !== 1'b0 || active !== 1'b0)
            $display("FAIL mr_idle: got ena=%b active=%b want 0 0", i2c_ena, active); else passed++;
        checks++; if ({err_nack, err_timeout, err_len} !== 3'b000)
            $display("FAIL mr_errs: got %b want 000", {err_nack, err_timeout, err_len}); else passed++;
        tick(); tick(); tick();
        checks++; if (done_cnt !== dc) $display("FAIL mr_no_done: got %0d want %0d", done_cnt, dc); else passed++;
        dc = done_cnt;
        start_xfer(7'h55, 5'd1, 5'd0);
        checks++; if (i2c_ena !== 1'b1 || i2c_data_wr !== 8'hA5)
            $display("FAIL mr_restart: got ena=%b data=%h want 1 a5", i2c_ena, i2c_data_wr); else passed++;
        master_byte(1'b0, 8'h00, e0, r0, d0);
        tick();
        checks++; if (done_cnt - dc !== 1 || active !== 1'b0)
            $display("FAIL mr_restart_done: got count=%0d active=%b want 1 0", done_cnt - dc, active); else passed++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dev_addr = '0; wr_len = '0; rd_len = '0;
        buf_we = 1'b0; buf_addr = '0; buf_wdata = '0;
        i2c_busy = 1'b0; i2c_ack_error = 1'b0; i2c_data_rd = '0;
        test_reset();
        test_write2();
        test_read();
        test_nack();
        test_timeout();
        test_err_len();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/i2c_seq.md
# i2c_seq

Transaction sequencer for the byte-level `i2c_master`. It executes a complete I2C transfer autonomously: a write phase of up to DEPTH bytes, an optional repeated-start read phase, then stop. It drives `i2c_master`'s enable/rw/data_wr handshake from an internal byte buffer that the GPMC register file fills and drains. The host no longer toggles enable per byte.

## Interface
Parameters:
- `ADDR_WIDTH`, 4: buffer index width; DEPTH = 1<<ADDR_WIDTH.
- `TO_WIDTH`, 16: width of the watchdog counter; timeout = 2^TO_WIDTH-1 cycles.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; ignored unless idle.
- `dev_addr` in 7: slave address, latched at accepted start.
- `wr_len` in ADDR_WIDTH+1: bytes to write, latched at start.
- `rd_len` in ADDR_WIDTH+1: bytes to read, latched at start.
- `buf_we` in 1: host buffer write strobe.
- `buf_addr` in ADDR_WIDTH: host buffer index.
- `buf_wdata` in 8: host write byte.
- `buf_rdata` out 8: host read byte, registered from `buf[buf_addr]`.
- `active` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at the end of every accepted or rejected start.
- `err_nack` out 1: sticky error flag, cleared at the next accepted start.
- `err_timeout` out 1: sticky error flag, cleared at the next accepted start.
- `err_len` out 1: sticky error flag, cleared at the next accepted start.
- `i2c_ena` out 1: drives the master's enable input.
- `i2c_addr` out 7: drives the master's address input.
- `i2c_rw` out 1: drives the master's rw input.
- `i2c_data_wr` out 8: drives the master's data_wr input.
- `i2c_busy` in 1: master's busy output.
- `i2c_ack_error` in 1: master's ack_error output.
- `i2c_data_rd` in 8: master's data_rd output.

## Operation
Master contract:
- `busy` rising means the master has latched ena/rw/data_wr for a byte.
- `busy` falling means that byte's ACK slot is complete. `ack_error` and `data_rd` are valid in that cycle.
- Keeping ena high at `busy` rise continues the transfer. A changed rw produces a repeated start.
- Dropping ena produces a stop after the current byte.

Edge detection uses the registered `busy_q`.
- rise = `busy & ~busy_q`
- fall = `~busy & busy_q`

Byte k of total N = wr_len+rd_len:
- Write byte k (k<wr_len): rw=0, data = buf[k].
- Read byte (k>=wr_len): rw=1. It is stored to buf[k] at fall, so read data lands after the write bytes.

States:
- IDLE: ena=0, active=0. On start:
  - If N==0 or N>DEPTH: set err_len, pulse done, stay IDLE.
  - Else: clear the err flags, latch the inputs, k=0, present byte 0, ena=1, go to RISE.
- RISE: on rise:
  - If k==N-1: ena<=0.
  - Else: present byte k+1 (rw and data).
  - Go to FALL.
- FALL: on fall:
  - If the byte was a read, write `i2c_data_rd` to buf[k].
  - If ack_error: go to ABORT with err_nack set.
  - Else if k==N-1: go to FIN.
  - Else: k<=k+1, go to RISE.
- FIN: pulse done, go to IDLE.
- ABORT: ena=0. When busy==0: pulse done, go to IDLE.
- Watchdog: reset on entry to RISE/FALL and on every rise/fall. At terminal count, set err_timeout and go to ABORT.

Other rules:
- Host `buf_we` while active is dropped.
- Host reads are always allowed.

## Timing
- Reset values:
  - state=IDLE
  - i2c_ena=0, i2c_rw=0, i2c_data_wr=0, i2c_addr=0
  - active=0, done=0, all err flags=0
  - buf_rdata=0
  - Buffer contents are not reset.
- Start is accepted → i2c_ena=1 with byte 0 valid on the next cycle. `active` rises in the same cycle.
- Next-byte rw/data is valid one cycle after rise, before the master samples it at the byte's end.
- done is asserted one cycle after the final fall (FIN). With ABORT, it is asserted one cycle after busy is observed low.
- buf_rdata latency is 1 cycle.
- Simultaneous events:
  - rise and timeout in the same cycle: the edge wins and the watchdog clears.
  - start while active: ignored.
  - buf_we and a read store to the same index in the same cycle: the sequencer wins (buf_we is already dropped while active).
- rst mid-transfer: ena drops in the same cycle the reset is sampled, with no done pulse. The master is reset by the same `rst`.

## Structure
- `i2c_seq_pkg` holds:
  - the state enum (IDLE, RISE, FALL, FIN, ABORT)
  - the length width ADDR_WIDTH+1
  - the default TO_WIDTH
- `i2c_seq_buf` sub-module: DEPTH×8 byte RAM.
  - Host port: read/write, registered read.
  - Sequencer port: combinational read at k, write at k.

## Test plan
- wr_len=2, rd_len=0, buf={0xA5,0x3C}, slave ACKs → data_wr 0xA5 then 0x3C, rw=0 throughout; ena drops after the second rise; done once; no errors.
- wr_len=1, rd_len=2, buf[0]=0x10, slave returns 0x11,0x22 → rw goes 0→1 after the first rise (repeated start); buf[1]=0x11, buf[2]=0x22 via buf_rdata; done once.
- wr_len=3, ack_error at the first fall → err_nack=1, ena low, done after busy is low; buf unchanged.
- TO_WIDTH=4, busy held low after start → err_timeout=1 after 15 cycles; done; active=0.
- wr_len=0, rd_len=0; separately wr_len=10, rd_len=7 (DEPTH=16) → err_len=1 and done on the next cycle; ena never rises.
- rst asserted in FALL of byte 1 → next cycle ena=0, active=0, flags=0, no done pulse; a new start works normally.
